// File: rtl/bcd_scan_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_display_pkg
//  Description : Shared types and segment constants for the BCD scan display.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_scan_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DP_DIGIT   = 2;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    typedef enum logic {
        MODE_TIMER     = 1'b0,
        MODE_STOPWATCH = 1'b1
    } mode_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam seg_t SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/bcd_scan_display_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : BCD digit to active-low 7-segment pattern; non-BCD shows dash.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_DIGIT[0];
            4'd1:    seg_o = SEG_DIGIT[1];
            4'd2:    seg_o = SEG_DIGIT[2];
            4'd3:    seg_o = SEG_DIGIT[3];
            4'd4:    seg_o = SEG_DIGIT[4];
            4'd5:    seg_o = SEG_DIGIT[5];
            4'd6:    seg_o = SEG_DIGIT[6];
            4'd7:    seg_o = SEG_DIGIT[7];
            4'd8:    seg_o = SEG_DIGIT[8];
            4'd9:    seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_display
//  Description : 4-digit multiplexed common-anode 7-segment driver with
//                per-frame snapshot, leading-zero blank, blink and guard time.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int SCAN_PERIOD  = 100_000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 125
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [3:0] minh,
    input  logic [3:0] minl,
    input  logic [3:0] sech,
    input  logic [3:0] secl,
    input  logic [3:0] s1h,
    input  logic [3:0] s1l,
    input  logic [3:0] s100h,
    input  logic [3:0] s100l,
    input  logic       lz_blank,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam int SEL_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [FRM_W-1:0] FRM_ONE   = FRM_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_DP    = SEL_W'(DP_DIGIT);

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic [FRM_W-1:0] frame_q,   frame_d;
    logic             blink_q,   blink_d;
    logic             started_q, started_d;
    bcd_t             snap_q [NUM_DIGITS];
    bcd_t             snap_d [NUM_DIGITS];

    logic [3:0]       an_q,  an_d;
    seg_t             seg_q, seg_d;
    logic             dp_q,  dp_d;

    bcd_t             live   [NUM_DIGITS];
    bcd_t             cur_digit;
    seg_t             cur_pattern;
    logic             tick;
    logic             frame_end;
    logic             anode_on;

    // Digit 0 is the rightmost position on the display.
    always_comb begin
        if (mode_e'(mode) == MODE_STOPWATCH) begin
            live[0] = s100l;
            live[1] = s100h;
            live[2] = s1l;
            live[3] = s1h;
        end else begin
            live[0] = secl;
            live[1] = sech;
            live[2] = minl;
            live[3] = minh;
        end
    end

    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        frame_end = tick && (sel_q == SEL_LAST);

        cnt_d     = tick ? '0 : cnt_q + CNT_ONE;
        sel_d     = sel_q;
        if (tick) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_ONE;
        end
        started_d = started_q | tick;

        snap_d = snap_q;
        if (frame_end) begin
            snap_d = live;
        end

        // Holding blink state at zero while disabled guarantees a visible restart.
        frame_d = frame_q;
        blink_d = blink_q;
        if (!blink_en) begin
            frame_d = '0;
            blink_d = 1'b0;
        end else if (frame_end) begin
            if (frame_q == FRM_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FRM_ONE;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (cur_pattern)
    );

    // Outputs are derived from the state being loaded on this edge.
    always_comb begin
        cur_digit = snap_d[sel_d];
        anode_on  = started_d && (cnt_d >= CNT_GUARD) && !blink_d;
        an_d      = anode_on ? ~(4'b0001 << sel_d) : 4'b1111;
        seg_d     = cur_pattern;
        if ((sel_d == SEL_LAST) && (cur_digit == 4'd0) && lz_blank) begin
            seg_d = SEG_OFF;
        end
        dp_d      = !(anode_on && (sel_d == SEL_DP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sel_q     <= '0;
            frame_q   <= '0;
            blink_q   <= 1'b0;
            started_q <= 1'b0;
            snap_q    <= '{default: 4'd0};
            an_q      <= 4'b1111;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
            started_q <= started_d;
            snap_q    <= snap_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_scan_display
//  Description : Self-checking bench for bcd_scan_display with a time-based
//                reference model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

    localparam int P  = 8;
    localparam int G  = 2;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [3:0] minh, minl, sech, secl;
    logic [3:0] s1h, s1l, s100h, s100l;
    logic       lz_blank;
    logic       blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;
    int t_rel    = 0;

    bcd_scan_display #(
        .SCAN_PERIOD  (P),
        .GUARD_CYCLES (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .minh     (minh),
        .minl     (minl),
        .sech     (sech),
        .secl     (secl),
        .s1h      (s1h),
        .s1l      (s1l),
        .s100h    (s100h),
        .s100l    (s100l),
        .lz_blank (lz_blank),
        .blink_en (blink_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts cycles since reset release.
    bit         m_valid = 1'b0;
    bit         m_rst   = 1'b1;
    int         m_t     = 0;
    int         m_fc    = 0;
    bit         m_ph    = 1'b0;
    bit         m_lz    = 1'b0;
    logic [3:0] m_snap [4] = '{default: 4'd0};

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_rst   <= 1'b1;
            m_t     <= 0;
            m_fc    <= 0;
            m_ph    <= 1'b0;
            m_lz    <= lz_blank;
            m_snap  <= '{default: 4'd0};
        end else if (m_valid) begin
            m_rst <= 1'b0;
            m_t   <= m_t + 1;
            m_lz  <= lz_blank;
            if ((m_t % P) == P - 1 && ((m_t / P) % 4) == 3) begin
                if (mode) m_snap <= '{s100l, s100h, s1l, s1h};
                else      m_snap <= '{secl, sech, minl, minh};
            end
            if (!blink_en) begin
                m_fc <= 0;
                m_ph <= 1'b0;
            end else if ((m_t % P) == P - 1 && ((m_t / P) % 4) == 3) begin
                if (m_fc == BF - 1) begin
                    m_fc <= 0;
                    m_ph <= !m_ph;
                end else begin
                    m_fc <= m_fc + 1;
                end
            end
        end
    end

    function automatic int sel_now();
        return (m_t / P) % 4;
    endfunction

    function automatic bit exp_vis();
        return !m_rst && (m_t >= P) && ((m_t % P) >= G) && !m_ph;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [3:0] exp_an();
        return exp_vis() ? ~(4'b0001 << sel_now()) : 4'b1111;
    endfunction

    function automatic logic [6:0] exp_seg();
        if (m_rst) return 7'h7F;
        if (sel_now() == 3 && m_snap[3] == 4'd0 && m_lz) return 7'h7F;
        return glyph(m_snap[sel_now()]);
    endfunction

    function automatic logic exp_dp();
        return !(exp_vis() && sel_now() == 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t_rel=%0d, time %0t)", name, act, exp, t_rel, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_an", {28'd0, an}, {28'd0, exp_an()});
            check("model_dp", {31'd0, dp}, {31'd0, exp_dp()});
            if (m_rst || exp_an() != 4'b1111)
                check("model_seg", {25'd0, seg}, {25'd0, exp_seg()});
        end
    end

    task automatic wait_to(input int target);
        while (t_rel < target) begin
            @(negedge clk);
            t_rel++;
        end
    endtask

    task automatic lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        check({name, "_an"},  {28'd0, an},  {28'd0, e_an});
        check({name, "_seg"}, {25'd0, seg}, {25'd0, e_seg});
        check({name, "_dp"},  {31'd0, dp},  {31'd0, e_dp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mode = 1'b0; lz_blank = 1'b0; blink_en = 1'b0;
        minh = 4'd1; minl = 4'd2; sech = 4'd3; secl = 4'd4;
        s1h = 4'd0; s1l = 4'd5; s100h = 4'd0; s100l = 4'd7;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t_rel = 0;
        lit("reset", 4'b1111, 7'h7F, 1'b1);

        wait_to(7);   check("prestart_an", {28'd0, an}, 32'hF);
        wait_to(9);   check("guard_an", {28'd0, an}, 32'hF);
        wait_to(10);  lit("presnap_d1", 4'b1101, 7'h40, 1'b1);
        wait_to(34);  lit("f2_d0", 4'b1110, 7'h19, 1'b1);
        wait_to(44);  minl = 4'd9; secl = 4'hC;
        wait_to(50);  lit("f2_d2_old", 4'b1011, 7'h24, 1'b0);
        wait_to(58);  lit("f2_d3", 4'b0111, 7'h79, 1'b1);
        wait_to(66);  lit("dash_d0", 4'b1110, 7'h3F, 1'b1);
        wait_to(82);  lit("f3_d2_new", 4'b1011, 7'h10, 1'b0);
        wait_to(90);  mode = 1'b1; lz_blank = 1'b1;
        wait_to(98);  lit("sw_d0", 4'b1110, 7'h78, 1'b1);
        wait_to(106); lit("sw_d1_zero", 4'b1101, 7'h40, 1'b1);
        wait_to(114); lit("sw_d2", 4'b1011, 7'h12, 1'b0);
        wait_to(122); lit("sw_d3_blank", 4'b0111, 7'h7F, 1'b1);

        for (int k = 128; k < 160; k++) begin
            wait_to(k);
            mode = ~mode;
        end
        wait_to(160); mode = 1'b0; blink_en = 1'b1;
        wait_to(162); lit("toggle_snap", 4'b1110, 7'h78, 1'b1);
        wait_to(170); check("blink_f1", {28'd0, an}, 32'hD);
        wait_to(230); check("blink_f3", {28'd0, an}, 32'hF);
        wait_to(260); check("blink_f4", {28'd0, an}, 32'hF);
        wait_to(290); check("blink_f5", {28'd0, an}, 32'hE);
        wait_to(360); check("blink_f7", {28'd0, an}, 32'hF);
        wait_to(458); check("blink_f10", {28'd0, an}, 32'hD);
        wait_to(486); check("blink_f11", {28'd0, an}, 32'hF);
        wait_to(487); blink_en = 1'b0;
        wait_to(488); check("unblink_guard", {28'd0, an}, 32'hF);
        wait_to(490); check("unblink_vis", {28'd0, an}, 32'hD);

        wait_to(500); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t_rel = 0;
        lit("midrst", 4'b1111, 7'h7F, 1'b1);
        wait_to(7);   check("rst_prestart", {28'd0, an}, 32'hF);
        wait_to(10);  lit("rst_d1", 4'b1101, 7'h40, 1'b1);
        wait_to(26);  lit("rst_d3_blank", 4'b0111, 7'h7F, 1'b1);
        wait_to(70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
